// File: rtl/vga_sync_gen_pkg.sv
// Shared timing constants, counter widths and the horizontal phase type for
// the 800x600 @ 72 Hz VGA timing generator.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 800;
  localparam int unsigned H_FP     = 56;
  localparam int unsigned H_SYNC_W = 120;
  localparam int unsigned H_BP     = 64;

  localparam int unsigned V_ACTIVE = 600;
  localparam int unsigned V_FP     = 37;
  localparam int unsigned V_SYNC_W = 6;
  localparam int unsigned V_BP     = 23;

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC_W + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC_W + V_BP;

  localparam int unsigned H_CNT_W = 11;
  localparam int unsigned V_CNT_W = 10;

  // Sync pulse widths carry a _W suffix so they do not clash with H_SYNC below.
  typedef enum logic [1:0] {
    H_ACT,
    H_FRONT,
    H_SYNC,
    H_BACK
  } h_phase_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Video timing bundle: enable goes into the generator, sync/qualifier/
// coordinate/strobe signals come out to the pixel pipeline.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic               enable;
  logic               hsync;
  logic               vsync;
  logic               video_on;
  logic [H_CNT_W-1:0] pixel_x;
  logic [V_CNT_W-1:0] pixel_y;
  logic               line_end;
  logic               frame_start;

  modport master (
    input  enable,
    output hsync, vsync, video_on, pixel_x, pixel_y, line_end, frame_start
  );

  modport slave (
    output enable,
    input  hsync, vsync, video_on, pixel_x, pixel_y, line_end, frame_start
  );

endinterface

// File: rtl/vga_sync_gen_mod_counter.sv
// Modulo counter 0..MAX with hold on en low; tc flags the terminal value so a
// cascaded counter can advance on the wrap.
module mod_counter #(
  parameter int unsigned     WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX  = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  // NOTE: clocked state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= (count == MAX) ? '0 : count + WIDTH'(1);
    end
  end

  assign tc = (count == MAX);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: cascaded h/v counters, horizontal phase FSM and a single
// bank of output registers so every output carries the same one-cycle latency.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned HACT   = H_ACTIVE,
  parameter int unsigned HFP    = H_FP,
  parameter int unsigned HSW    = H_SYNC_W,
  parameter int unsigned HBP    = H_BP,
  parameter int unsigned VACT   = V_ACTIVE,
  parameter int unsigned VFP    = V_FP,
  parameter int unsigned VSW    = V_SYNC_W,
  parameter int unsigned VBP    = V_BP,
  parameter bit          HS_POL = 1'b1,
  parameter bit          VS_POL = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  vga_sync_gen_if.master vga
);

  localparam int unsigned HTOT = HACT + HFP + HSW + HBP;
  localparam int unsigned VTOT = VACT + VFP + VSW + VBP;

  // Last count of each horizontal phase; the FSM steps on equality only.
  localparam logic [H_CNT_W-1:0] H_ACT_END   = H_CNT_W'(HACT - 1);
  localparam logic [H_CNT_W-1:0] H_FRONT_END = H_CNT_W'(HACT + HFP - 1);
  localparam logic [H_CNT_W-1:0] H_SYNC_END  = H_CNT_W'(HACT + HFP + HSW - 1);
  localparam logic [H_CNT_W-1:0] H_LAST      = H_CNT_W'(HTOT - 1);

  localparam logic [V_CNT_W-1:0] V_ACT_N      = V_CNT_W'(VACT);
  localparam logic [V_CNT_W-1:0] V_SYNC_FIRST = V_CNT_W'(VACT + VFP);
  localparam logic [V_CNT_W-1:0] V_SYNC_LAST  = V_CNT_W'(VACT + VFP + VSW - 1);
  localparam logic [V_CNT_W-1:0] V_LAST       = V_CNT_W'(VTOT - 1);

  logic [H_CNT_W-1:0] h_cnt;
  logic [V_CNT_W-1:0] v_cnt;
  logic               h_tc;
  logic               unused_v_tc;
  logic               v_en;

  h_phase_t h_state, h_state_nxt;

  logic hsync_d, vsync_d, video_on_d, line_end_d, frame_start_d;

  mod_counter #(.WIDTH(H_CNT_W), .MAX(H_LAST)) u_h_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (vga.enable),
    .count (h_cnt),
    .tc    (h_tc)
  );

  assign v_en = vga.enable & h_tc;

  mod_counter #(.WIDTH(V_CNT_W), .MAX(V_LAST)) u_v_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (v_en),
    .count (v_cnt),
    .tc    (unused_v_tc)
  );

  // h_state always names the phase of the current h_cnt value, so both reset
  // together and advance on the same enabled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_state <= H_ACT;
    end else if (vga.enable) begin
      h_state <= h_state_nxt;
    end
  end

  // NOTE: next-state gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    h_state_nxt = h_state;
    case (h_state)
      H_ACT:   if (h_cnt == H_ACT_END)   h_state_nxt = H_FRONT;
      H_FRONT: if (h_cnt == H_FRONT_END) h_state_nxt = H_SYNC;
      H_SYNC:  if (h_cnt == H_SYNC_END)  h_state_nxt = H_BACK;
      H_BACK:  if (h_cnt == H_LAST)      h_state_nxt = H_ACT;
      default: h_state_nxt = H_ACT;
    endcase
  end

  assign hsync_d       = (h_state == H_SYNC) ? HS_POL : ~HS_POL;
  assign vsync_d       = (v_cnt >= V_SYNC_FIRST && v_cnt <= V_SYNC_LAST) ? VS_POL : ~VS_POL;
  assign video_on_d    = (h_state == H_ACT) && (v_cnt < V_ACT_N);
  assign line_end_d    = h_tc;
  assign frame_start_d = (h_cnt == '0) && (v_cnt == '0);

  // Outputs hold while enable is low, including any strobe that is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga.hsync       <= ~HS_POL;
      vga.vsync       <= ~VS_POL;
      vga.video_on    <= 1'b0;
      vga.pixel_x     <= '0;
      vga.pixel_y     <= '0;
      vga.line_end    <= 1'b0;
      vga.frame_start <= 1'b0;
    end else if (vga.enable) begin
      vga.hsync       <= hsync_d;
      vga.vsync       <= vsync_d;
      vga.video_on    <= video_on_d;
      vga.pixel_x     <= h_cnt;
      vga.pixel_y     <= v_cnt;
      vga.line_end    <= line_end_d;
      vga.frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size instance for line-level timing, two reduced
// geometry instances (both sync polarities) for frame-level behaviour.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  // Reduced geometry: 24 x 12 total, frame = 288 cycles.
  localparam int S_HA = 16, S_HFP = 2, S_HSW = 3, S_HBP = 3;
  localparam int S_VA = 6,  S_VFP = 2, S_VSW = 2, S_VBP = 2;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        vo;
    logic        le;
    logic        fs;
    logic [10:0] px;
    logic [9:0]  py;
  } out_t;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;

  always #5 clk = ~clk;

  vga_sync_gen_if bus_a ();
  vga_sync_gen_if bus_b ();
  vga_sync_gen_if bus_c ();

  assign bus_a.enable = enable;
  assign bus_b.enable = enable;
  assign bus_c.enable = enable;

  vga_sync_gen u_a (.clk(clk), .rst_n(rst_n), .vga(bus_a));

  vga_sync_gen #(
    .HACT(S_HA), .HFP(S_HFP), .HSW(S_HSW), .HBP(S_HBP),
    .VACT(S_VA), .VFP(S_VFP), .VSW(S_VSW), .VBP(S_VBP),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_b (.clk(clk), .rst_n(rst_n), .vga(bus_b));

  vga_sync_gen #(
    .HACT(S_HA), .HFP(S_HFP), .HSW(S_HSW), .HBP(S_HBP),
    .VACT(S_VA), .VFP(S_VFP), .VSW(S_VSW), .VBP(S_VBP),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_c (.clk(clk), .rst_n(rst_n), .vga(bus_c));

  out_t obs_a, obs_b, obs_c;
  assign obs_a = {bus_a.hsync, bus_a.vsync, bus_a.video_on, bus_a.line_end,
                  bus_a.frame_start, bus_a.pixel_x, bus_a.pixel_y};
  assign obs_b = {bus_b.hsync, bus_b.vsync, bus_b.video_on, bus_b.line_end,
                  bus_b.frame_start, bus_b.pixel_x, bus_b.pixel_y};
  assign obs_c = {bus_c.hsync, bus_c.vsync, bus_c.video_on, bus_c.line_end,
                  bus_c.frame_start, bus_c.pixel_x, bus_c.pixel_y};

  int n_total = 0;
  int n_bad   = 0;

  // Model state: index 0 = full geometry, 1 = reduced geometry.
  int mcx [2];
  int mcy [2];
  int msx [2];
  int msy [2];
  bit mval;
  int m_ht [2] = '{1040, 24};
  int m_vt [2] = '{666, 12};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic out_t model_out(input int m, input int x, input int y,
                                     input bit hp, input bit vp, input bit valid);
    out_t o;
    int ha, hfp, hsw, hbp, va, vfp, vsw;
    if (m == 0) begin
      ha = 800; hfp = 56; hsw = 120; hbp = 64; va = 600; vfp = 37; vsw = 6;
    end else begin
      ha = S_HA; hfp = S_HFP; hsw = S_HSW; hbp = S_HBP; va = S_VA; vfp = S_VFP; vsw = S_VSW;
    end
    o = '0;
    o.hs = ~hp;
    o.vs = ~vp;
    if (valid) begin
      o.hs = (x >= ha + hfp && x < ha + hfp + hsw) ? hp : ~hp;
      o.vs = (y >= va + vfp && y < va + vfp + vsw) ? vp : ~vp;
      o.vo = (x < ha) && (y < va);
      o.le = (x == ha + hfp + hsw + hbp - 1);
      o.fs = (x == 0) && (y == 0);
      o.px = 11'(x);
      o.py = 10'(y);
    end
    return o;
  endfunction

  task automatic cmp(input string tag, input out_t got, input out_t exp);
    check({tag, ".hsync"},       32'(got.hs), 32'(exp.hs));
    check({tag, ".vsync"},       32'(got.vs), 32'(exp.vs));
    check({tag, ".video_on"},    32'(got.vo), 32'(exp.vo));
    check({tag, ".line_end"},    32'(got.le), 32'(exp.le));
    check({tag, ".frame_start"}, 32'(got.fs), 32'(exp.fs));
    check({tag, ".pixel_x"},     32'(got.px), 32'(exp.px));
    check({tag, ".pixel_y"},     32'(got.py), 32'(exp.py));
  endtask

  task automatic check_all(input string tag);
    cmp({tag, " A"}, obs_a, model_out(0, msx[0], msy[0], 1'b1, 1'b1, mval));
    cmp({tag, " B"}, obs_b, model_out(1, msx[1], msy[1], 1'b1, 1'b1, mval));
    cmp({tag, " C"}, obs_c, model_out(1, msx[1], msy[1], 1'b0, 1'b0, mval));
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mcx[m] = 0; mcy[m] = 0; msx[m] = 0; msy[m] = 0;
    end
    mval = 1'b0;
  endtask

  // One clock: model advances on enabled edges, outputs sampled at the negedge.
  task automatic step();
    @(posedge clk);
    if (enable && rst_n) begin
      for (int m = 0; m < 2; m++) begin
        msx[m] = mcx[m];
        msy[m] = mcy[m];
        mcx[m] = (mcx[m] + 1) % m_ht[m];
        if (mcx[m] == 0) mcy[m] = (mcy[m] + 1) % m_vt[m];
      end
      mval = 1'b1;
    end
    @(negedge clk);
  endtask

  int  hs_run, hs_first, vo_fall, le_cnt, le_x, fs_last, n_fs, b_vs_len, guard;
  bit  prev_vo, b_vs_prev;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    check("rst a.hsync",       32'(obs_a.hs), 0);
    check("rst a.vsync",       32'(obs_a.vs), 0);
    check("rst a.video_on",    32'(obs_a.vo), 0);
    check("rst a.pixel_x",     32'(obs_a.px), 0);
    check("rst a.pixel_y",     32'(obs_a.py), 0);
    check("rst a.line_end",    32'(obs_a.le), 0);
    check("rst a.frame_start", 32'(obs_a.fs), 0);
    check("rst c.hsync",       32'(obs_c.hs), 1);
    check("rst c.vsync",       32'(obs_c.vs), 1);
    check_all("rst");

    rst_n  = 1'b1;
    enable = 1'b1;
    step();
    check("first a.pixel_x",     32'(obs_a.px), 0);
    check("first a.pixel_y",     32'(obs_a.py), 0);
    check("first a.frame_start", 32'(obs_a.fs), 1);
    check("first a.video_on",    32'(obs_a.vo), 1);
    check("first a.hsync",       32'(obs_a.hs), 0);
    check("first a.vsync",       32'(obs_a.vs), 0);
    check("first c.hsync",       32'(obs_c.hs), 1);
    check_all("first");

    // Rest of line 0 on A; several whole frames pass on B/C meanwhile.
    hs_run = 0; hs_first = -1; vo_fall = -1; le_cnt = 0; le_x = -1;
    fs_last = 0; n_fs = 0; b_vs_len = 0; prev_vo = 1'b1; b_vs_prev = 1'b0;
    for (int i = 1; i < 1040; i++) begin
      step();
      check_all("line");
      if (obs_a.hs) begin
        hs_run++;
        if (hs_first < 0) hs_first = int'(obs_a.px);
      end
      if (prev_vo && !obs_a.vo && vo_fall < 0) vo_fall = int'(obs_a.px);
      prev_vo = obs_a.vo;
      if (obs_a.le) begin
        le_cnt++;
        le_x = int'(obs_a.px);
      end
      if (obs_b.fs) begin
        check("b frame period", 32'(i - fs_last), 288);
        fs_last = i;
        n_fs++;
      end
      if (obs_b.vs && !b_vs_prev) begin
        check("b vsync rise pixel_y", 32'(obs_b.py), 8);
        check("b vsync rise pixel_x", 32'(obs_b.px), 0);
        b_vs_len = 0;
      end
      if (obs_b.vs) b_vs_len++;
      if (!obs_b.vs && b_vs_prev) check("b vsync width", 32'(b_vs_len), 48);
      b_vs_prev = obs_b.vs;
    end
    check("a hsync width",     32'(hs_run),   120);
    check("a hsync first x",   32'(hs_first), 856);
    check("a video_on fall x", 32'(vo_fall),  800);
    check("a line_end count",  32'(le_cnt),   1);
    check("a line_end x",      32'(le_x),     1039);
    check("b frame starts",    32'(n_fs),     3);

    // Freeze A at pixel_x = 855 for 500 cycles.
    guard = 0;
    while (msx[0] != 855 && guard < 2000) begin
      step();
      check_all("to855");
      guard++;
    end
    check("reach 855 in budget", 32'(guard < 2000), 1);
    enable = 1'b0;
    for (int i = 0; i < 500; i++) begin
      step();
      check_all("frozen");
    end
    check("frozen a.pixel_x", 32'(obs_a.px), 855);
    check("frozen a.hsync",   32'(obs_a.hs), 0);
    enable = 1'b1;
    step();
    check("resume a.pixel_x", 32'(obs_a.px), 856);
    check("resume a.hsync",   32'(obs_a.hs), 1);
    check_all("resume");

    // A strobe that is high when enable drops stays high.
    guard = 0;
    while (msx[1] != 23 && guard < 100) begin
      step();
      check_all("to_le");
      guard++;
    end
    check("reach line_end in budget", 32'(guard < 100), 1);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("held b.line_end", 32'(obs_b.le), 1);
    end
    enable = 1'b1;

    // Asynchronous reset mid-frame at B position (10,3).
    guard = 0;
    while (!(msx[1] == 10 && msy[1] == 3) && guard < 400) begin
      step();
      check_all("to_mid");
      guard++;
    end
    check("reach mid-frame in budget", 32'(guard < 400), 1);
    check("mid b.pixel_x", 32'(obs_b.px), 10);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async b.pixel_x",     32'(obs_b.px), 0);
    check("async b.pixel_y",     32'(obs_b.py), 0);
    check("async a.pixel_x",     32'(obs_a.px), 0);
    check("async c.hsync",       32'(obs_c.hs), 1);
    check("async b.video_on",    32'(obs_b.vo), 0);
    check_all("async");
    repeat (3) begin
      step();
      check_all("in_rst");
    end
    rst_n = 1'b1;
    step();
    check("restart a.frame_start", 32'(obs_a.fs), 1);
    check("restart b.frame_start", 32'(obs_b.fs), 1);
    check("restart b.pixel_x",     32'(obs_b.px), 0);
    check("restart b.pixel_y",     32'(obs_b.py), 0);
    check_all("restart");
    for (int i = 0; i < 30; i++) begin
      step();
      check_all("after");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA timing generator for 800x600 @ 72 Hz, clocked by the 50 MHz pixel clock produced by the clock divider. It produces horizontal/vertical sync, the active-video qualifier, the current pixel coordinates and line/frame strobes. The pixel-colour logic and the RTC text overlay consume these outputs.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP, 56, horizontal front porch (pixels)
- H_SYNC, 120, hsync pulse width (pixels)
- H_BP, 64, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BP, 23, vertical back porch (lines)
- HS_POL, 1, hsync active level (1 = active high)
- VS_POL, 1, vsync active level

Ports:
- clk  in  1  pixel clock, 50 MHz; rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  counting enable; low freezes all counters and outputs
- hsync  out  1  horizontal sync, level per HS_POL
- vsync  out  1  vertical sync, level per VS_POL
- video_on  out  1  high during visible pixels
- pixel_x  out  11  horizontal count, 0..H_TOTAL-1
- pixel_y  out  10  vertical count, 0..V_TOTAL-1
- line_end  out  1  one-cycle pulse on last pixel of each line
- frame_start  out  1  one-cycle pulse on pixel (0,0)

## Operation
- H_TOTAL = 1040 (H_ACTIVE+H_FP+H_SYNC+H_BP); V_TOTAL = 666.
- h_cnt: 11-bit counter that increments on each enabled cycle. It wraps H_TOTAL-1 -> 0. At that wrap v_cnt increments; v_cnt wraps V_TOTAL-1 -> 0.
- Horizontal phase FSM, re-evaluated each enabled cycle from h_cnt:
  - H_ACT (0..799) -> H_FRONT (800..855) -> H_SYNC (856..975) -> H_BACK (976..1039) -> H_ACT.
  - Vertical phase is decoded the same way from v_cnt: active 0..599, front 600..636, sync 637..642, back 643..665.
- Decode rules:
  - hsync = HS_POL while h_cnt is in 856..975; otherwise it is ~HS_POL.
  - vsync = VS_POL while v_cnt is in 637..642; otherwise it is ~VS_POL.
  - video_on = (h_cnt < 800) && (v_cnt < 600).
  - pixel_x = h_cnt and pixel_y = v_cnt, unmasked; consumers gate them with video_on.
  - line_end = (h_cnt == 1039).
  - frame_start = (h_cnt == 0 && v_cnt == 0).
- All arithmetic is unsigned with no overflow. Counters compare with ==, not >=.
- enable low:
  - h_cnt, v_cnt, FSM state and every output register hold their value.
  - A pulse output that is high stays high while frozen. The consumer qualifies pulses with enable.
- Reset (async assert, any time including mid-frame):
  - h_cnt = 0, v_cnt = 0, FSM = H_ACT.
  - hsync = ~HS_POL, vsync = ~VS_POL.
  - video_on = 0, pixel_x = 0, pixel_y = 0, line_end = 0, frame_start = 0.
- Reset deassertion is assumed to be synchronised externally. After release, counting restarts from (0,0).

## Timing
- All outputs are registered. Each output reflects the decode of the counter state one cycle earlier; the latency is identical on all outputs, so they stay mutually aligned.
- First enabled edge after reset release:
  - Counters go to (1,0).
  - Outputs show the decode of (0,0): video_on = 1 and frame_start = 1.
- Line period: 1040 enabled cycles. Frame period: 692,640 enabled cycles (72.19 Hz at 50 MHz).
- Sync widths: hsync active for exactly 120 consecutive enabled cycles. vsync active for exactly 6 lines (6240 cycles); its edges coincide with the output cycle showing h = 0.
- Counter wrap case, h=1039 and v=665:
  - That cycle shows line_end = 1.
  - The next cycle shows frame_start = 1.
  - No cycle is skipped or duplicated.

## Structure
- Package vga_timing_pkg holds:
  - the 800x600@72 constants (H_/V_ ACTIVE, FP, SYNC, BP);
  - H_TOTAL and V_TOTAL;
  - the counter widths (11 and 10 bits);
  - the h-phase enum {H_ACT, H_FRONT, H_SYNC, H_BACK}.
- Sub-module mod_counter (parameters WIDTH and MAX; ports clk, rst_n, en, count, tc) is instantiated twice:
  - horizontal instance: en = enable;
  - vertical instance: en = enable & h_tc.
- The top level contains the FSM, the decode and the output registers.

## Test plan
- Reset, then enable=1 held -> first output cycle shows pixel_x=0, pixel_y=0, frame_start=1, video_on=1, hsync=0, vsync=0.
- Run one line -> line_end high exactly at pixel_x=1039. hsync goes high at pixel_x=856 and is high for 120 cycles. video_on falls at pixel_x=800.
- Run two full frames -> frame_start pulses are 692,640 cycles apart. vsync is high for 6240 cycles starting at pixel_y=637, pixel_x=0. video_on=0 for all pixel_y >= 600.
- Drop enable for 500 cycles at pixel_x=855 -> all outputs frozen during the gap. On re-enable, the next output is pixel_x=856 with hsync=1.
- Assert rst_n low at (pixel_x=400, pixel_y=300) for 3 cycles -> outputs take reset values immediately (asynchronously). After release, counting restarts from (0,0) with frame_start=1.
- HS_POL=0, VS_POL=0 build -> sync outputs idle high and pulse low with the same widths and positions as the active-high build.
